// File: rtl/mips_cpu_pkg.sv
// Shared MIPS pipeline types: memory-op descriptor, register names, MEM-stage state and exceptions.
package mips_cpu_pkg;

  typedef enum logic [1:0] {MEM_NONE, MEM_LOAD, MEM_STORE} ls_type_e;
  typedef enum logic [1:0] {LS_BYTE, LS_HALF, LS_WORD} ls_width_e;

  typedef struct packed {
    ls_type_e  ls_type;
    ls_width_e ls_width;
    logic      ls_signed;
  } memop_struct;

  typedef enum logic [4:0] {
    R0,  R1,  R2,  R3,  R4,  R5,  R6,  R7,  R8,  R9,  R10, R11, R12, R13, R14, R15,
    R16, R17, R18, R19, R20, R21, R22, R23, R24, R25, R26, R27, R28, R29, R30, R31
  } reg_enum;

  typedef enum logic {IDLE, BUSY} mem_state_e;

  typedef enum logic [1:0] {EXC_NONE, EXC_ADEL, EXC_ADES, EXC_BUSERR} mem_excp_e;

  // Byte-enable pattern of an access before it is shifted to its lane offset.
  function automatic logic [3:0] width_be(ls_width_e w);
    case (w)
      LS_BYTE: return 4'b0001;
      LS_HALF: return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane logic for the MEM stage: alignment check, store lane replication, load extract/extend.
module mem_lane_align
  import mips_cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  localparam int unsigned NB = DATA_W / 8,
  localparam int unsigned OB = $clog2(NB)
) (
  input  memop_struct       memop,
  input  logic [OB-1:0]     off,
  input  logic [31:0]       wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic              aligned,
  output logic [NB-1:0]     be,
  output logic [DATA_W-1:0] dm_wdata,
  output logic [31:0]       ld_data
);

  logic [OB+2:0]     shamt;
  logic [DATA_W-1:0] shifted;

  assign shamt   = {off, 3'b000};
  assign shifted = rdata >> shamt;
  assign be      = NB'(width_be(memop.ls_width)) << off;

  // Replicating the datum across the bus puts the right byte in every enabled lane.
  always_comb begin
    aligned  = 1'b1;
    dm_wdata = {(DATA_W / 32){wdata}};
    ld_data  = shifted[31:0];
    case (memop.ls_width)
      LS_BYTE: begin
        dm_wdata = {NB{wdata[7:0]}};
        ld_data  = {{24{memop.ls_signed & shifted[7]}}, shifted[7:0]};
      end
      LS_HALF: begin
        aligned  = ~off[0];
        dm_wdata = {(NB / 2){wdata[15:0]}};
        ld_data  = {{16{memop.ls_signed & shifted[15]}}, shifted[15:0]};
      end
      default: aligned = (off[1:0] == 2'b00);
    endcase
  end

endmodule

// File: rtl/stage_mem_mcu.sv
// MEM pipeline stage with a multi-cycle data-memory handshake, wait-state abort and
// registered MEM/WB outputs.
module stage_mem_mcu
  import mips_cpu_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned MAX_WAIT = 15,
  localparam int unsigned NB = DATA_W / 8,
  localparam int unsigned OB = $clog2(NB)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_i_valid,
  input  memop_struct       mem_i_memop,
  input  logic [ADDR_W-1:0] mem_i_addr,
  input  logic [31:0]       mem_i_wdata,
  input  logic              mem_i_rfwe,
  input  reg_enum           mem_i_rfwa,
  input  logic [31:0]       mem_i_alures,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [NB-1:0]     dm_be,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  input  logic              dm_ack,
  output logic              mem_o_stall,
  output logic              mem_o_valid,
  output logic              mem_o_rfwe,
  output reg_enum           mem_o_rfwa,
  output logic [31:0]       mem_o_alures,
  output logic [31:0]       mem_o_rdata,
  output logic              mem_o_dm2rf,
  output logic [1:0]        mem_o_excp
);

  mem_state_e        state_q, state_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic              aligned;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] wdata_lanes;
  logic [31:0]       ld_data;
  logic              mem_op, go, busy, timeout, done, is_load, is_store;
  mem_excp_e         excp;

  mem_lane_align #(
    .DATA_W(DATA_W)
  ) u_lane (
    .memop   (mem_i_memop),
    .off     (mem_i_addr[OB-1:0]),
    .wdata   (mem_i_wdata),
    .rdata   (dm_rdata),
    .aligned (aligned),
    .be      (be),
    .dm_wdata(wdata_lanes),
    .ld_data (ld_data)
  );

  assign is_load  = mem_i_memop.ls_type == MEM_LOAD;
  assign is_store = mem_i_memop.ls_type == MEM_STORE;
  assign mem_op   = mem_i_valid & (mem_i_memop.ls_type != MEM_NONE);
  assign go       = mem_op & aligned;
  assign busy     = state_q == BUSY;
  assign timeout  = busy & (wait_cnt_q == 8'(MAX_WAIT - 1));
  assign done     = busy & (dm_ack | timeout);

  assign mem_o_stall = go & ~done;

  // The DM side only sees a live transaction while BUSY; otherwise it reads all zero.
  assign dm_req   = busy;
  assign dm_we    = busy & is_store;
  assign dm_addr  = busy ? {mem_i_addr[ADDR_W-1:OB], {OB{1'b0}}} : '0;
  assign dm_be    = busy ? be : '0;
  assign dm_wdata = busy ? wdata_lanes : '0;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d    = BUSY;
          wait_cnt_d = '0;
        end
      end
      BUSY: begin
        if (done) begin
          state_d = IDLE;
        end else if (wait_cnt_q != 8'hFF) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // An ack in the final wait cycle counts as a normal completion.
  always_comb begin
    excp = EXC_NONE;
    if (mem_op && !aligned) begin
      excp = is_store ? EXC_ADES : EXC_ADEL;
    end else if (timeout && !dm_ack) begin
      excp = EXC_BUSERR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      mem_o_valid  <= 1'b0;
      mem_o_rfwe   <= 1'b0;
      mem_o_rfwa   <= R0;
      mem_o_alures <= '0;
      mem_o_rdata  <= '0;
      mem_o_dm2rf  <= 1'b0;
      mem_o_excp   <= EXC_NONE;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (mem_i_valid && !mem_o_stall) begin
        mem_o_valid  <= 1'b1;
        mem_o_rfwe   <= mem_i_rfwe & (excp == EXC_NONE);
        mem_o_rfwa   <= mem_i_rfwa;
        mem_o_alures <= mem_i_alures;
        mem_o_rdata  <= (is_load && busy && dm_ack) ? ld_data : '0;
        mem_o_dm2rf  <= is_load & (excp == EXC_NONE);
        mem_o_excp   <= excp;
      end else begin
        mem_o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stage_mem_mcu.sv
// Directed bench for stage_mem_mcu: 32-bit and 64-bit instances, hand-computed expectations.
module tb_stage_mem_mcu;
  import mips_cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  memop_struct mop;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic        rfwe;
  reg_enum     rfwa;
  logic [31:0] alures;

  logic        req32, we32, ack32, stall32, ov32, orfwe32, odm2rf32;
  logic [15:0] addr32;
  logic [3:0]  be32;
  logic [31:0] wd32, rdata32, oalu32, ordata32;
  reg_enum     orfwa32;
  logic [1:0]  oexcp32;

  logic        req64, we64, ack64, stall64, ov64, orfwe64, odm2rf64;
  logic [15:0] addr64;
  logic [7:0]  be64;
  logic [63:0] wd64, rdata64;
  logic [31:0] oalu64, ordata64;
  reg_enum     orfwa64;
  logic [1:0]  oexcp64;

  int n_vec = 0;
  int n_err = 0;
  int cnt;
  logic done;

  always #5 clk = ~clk;

  stage_mem_mcu #(.DATA_W(32), .ADDR_W(16), .MAX_WAIT(15)) dut32 (
    .clk(clk), .rst(rst), .mem_i_valid(valid), .mem_i_memop(mop), .mem_i_addr(addr),
    .mem_i_wdata(wdata), .mem_i_rfwe(rfwe), .mem_i_rfwa(rfwa), .mem_i_alures(alures),
    .dm_req(req32), .dm_we(we32), .dm_addr(addr32), .dm_be(be32), .dm_wdata(wd32),
    .dm_rdata(rdata32), .dm_ack(ack32), .mem_o_stall(stall32), .mem_o_valid(ov32),
    .mem_o_rfwe(orfwe32), .mem_o_rfwa(orfwa32), .mem_o_alures(oalu32),
    .mem_o_rdata(ordata32), .mem_o_dm2rf(odm2rf32), .mem_o_excp(oexcp32)
  );

  stage_mem_mcu #(.DATA_W(64), .ADDR_W(16), .MAX_WAIT(15)) dut64 (
    .clk(clk), .rst(rst), .mem_i_valid(valid), .mem_i_memop(mop), .mem_i_addr(addr),
    .mem_i_wdata(wdata), .mem_i_rfwe(rfwe), .mem_i_rfwa(rfwa), .mem_i_alures(alures),
    .dm_req(req64), .dm_we(we64), .dm_addr(addr64), .dm_be(be64), .dm_wdata(wd64),
    .dm_rdata(rdata64), .dm_ack(ack64), .mem_o_stall(stall64), .mem_o_valid(ov64),
    .mem_o_rfwe(orfwe64), .mem_o_rfwa(orfwa64), .mem_o_alures(oalu64),
    .mem_o_rdata(ordata64), .mem_o_dm2rf(odm2rf64), .mem_o_excp(oexcp64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic present(input ls_type_e t, input ls_width_e w, input logic s,
                         input logic [15:0] a, input logic [31:0] d);
    valid  = 1'b1;
    mop    = '{t, w, s};
    addr   = a;
    wdata  = d;
    rfwe   = 1'b1;
    rfwa   = R8;
    alures = {16'h0, a};
  endtask

  // Enter BUSY on the next edge and ack in that first BUSY cycle; returns at the negedge.
  task automatic ack_now();
    @(posedge clk); #1;
    ack32 = 1'b1;
    @(negedge clk);
  endtask

  // Let the completing edge pass, withdraw the op, return at the negedge with outputs loaded.
  task automatic finish_op();
    @(posedge clk); #1;
    ack32 = 1'b0;
    valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; valid = 1'b0; mop = '{MEM_NONE, LS_WORD, 1'b0}; addr = '0; wdata = '0;
    rfwe = 1'b0; rfwa = R0; alures = '0;
    ack32 = 1'b0; rdata32 = '0; ack64 = 1'b0; rdata64 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", req32, 0);
    chk("rst_valid", ov32, 0);
    chk("rst_excp", oexcp32, 0);
    chk("rst_rdata", ordata32, 0);
    chk("rst_rfwe", orfwe32, 0);
    chk("rst_stall", stall32, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // LW, ack in first BUSY cycle
    present(MEM_LOAD, LS_WORD, 1'b0, 16'h0008, 32'h0);
    rdata32 = 32'hDEADBEEF;
    @(negedge clk);
    chk("lw_stall_idle", stall32, 1);
    chk("lw_noreq_idle", req32, 0);
    ack_now();
    chk("lw_req", req32, 1);
    chk("lw_stall_ack", stall32, 0);
    chk("lw_addr", addr32, 16'h0008);
    chk("lw_be", be32, 4'hF);
    chk("lw_we", we32, 0);
    finish_op();
    chk("lw_valid", ov32, 1);
    chk("lw_rdata", ordata32, 32'hDEADBEEF);
    chk("lw_excp", oexcp32, 0);
    chk("lw_rfwe", orfwe32, 1);
    chk("lw_dm2rf", odm2rf32, 1);
    chk("lw_req_drop", req32, 0);

    // LB / LBU from the top byte lane
    present(MEM_LOAD, LS_BYTE, 1'b1, 16'h0003, 32'h0);
    rdata32 = 32'h80FFFFFF;
    ack_now();
    chk("lb_be", be32, 4'b1000);
    finish_op();
    chk("lb_rdata", ordata32, 32'hFFFFFF80);
    present(MEM_LOAD, LS_BYTE, 1'b0, 16'h0003, 32'h0);
    ack_now();
    finish_op();
    chk("lbu_rdata", ordata32, 32'h00000080);

    // SH to upper half
    present(MEM_STORE, LS_HALF, 1'b0, 16'h0002, 32'h00001234);
    ack_now();
    chk("sh_be", be32, 4'b1100);
    chk("sh_wdata_hi", wd32[31:16], 16'h1234);
    chk("sh_we", we32, 1);
    chk("sh_addr", addr32, 16'h0000);
    finish_op();
    chk("sh_valid", ov32, 1);
    chk("sh_excp", oexcp32, 0);
    chk("sh_dm2rf", odm2rf32, 0);

    // Misaligned LW -> ADEL, no request
    present(MEM_LOAD, LS_WORD, 1'b0, 16'h0006, 32'h0);
    @(negedge clk);
    chk("adel_stall", stall32, 0);
    chk("adel_req", req32, 0);
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    chk("adel_valid", ov32, 1);
    chk("adel_excp", oexcp32, 1);
    chk("adel_rfwe", orfwe32, 0);
    chk("adel_dm2rf", odm2rf32, 0);
    chk("adel_req_after", req32, 0);

    // Misaligned SH -> ADES
    present(MEM_STORE, LS_HALF, 1'b0, 16'h0001, 32'h0);
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    chk("ades_excp", oexcp32, 2);
    chk("ades_rfwe", orfwe32, 0);

    // Non-memory op passes straight through
    present(MEM_NONE, LS_WORD, 1'b0, 16'hCAFE, 32'h0);
    @(negedge clk);
    chk("alu_stall", stall32, 0);
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    chk("alu_valid", ov32, 1);
    chk("alu_alures", oalu32, 32'h0000CAFE);
    chk("alu_rfwe", orfwe32, 1);
    chk("alu_rfwa", orfwa32, R8);
    chk("alu_dm2rf", odm2rf32, 0);

    // SW never acked -> BUSERR after 15 request cycles
    present(MEM_STORE, LS_WORD, 1'b0, 16'h0010, 32'h55AA55AA);
    cnt = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (req32) cnt++;
      if (req32 && !stall32) done = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("to_req_cycles", cnt, 15);
    chk("to_released", done, 1);
    chk("to_we", we32, 1);
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    chk("to_valid", ov32, 1);
    chk("to_excp", oexcp32, 3);
    chk("to_rfwe", orfwe32, 0);
    chk("to_rdata", ordata32, 0);
    chk("to_req_drop", req32, 0);

    // Stray ack while idle
    ack32 = 1'b1;
    @(posedge clk); #1;
    ack32 = 1'b0;
    @(negedge clk);
    chk("stray_valid", ov32, 0);
    chk("stray_req", req32, 0);

    // Ack lands in the last allowed wait cycle: completes normally
    present(MEM_LOAD, LS_WORD, 1'b0, 16'h0020, 32'h0);
    rdata32 = 32'h13579BDF;
    @(posedge clk);
    repeat (14) @(posedge clk);
    #1;
    ack32 = 1'b1;
    @(negedge clk);
    chk("last_req", req32, 1);
    chk("last_stall", stall32, 0);
    finish_op();
    chk("last_excp", oexcp32, 0);
    chk("last_rdata", ordata32, 32'h13579BDF);
    chk("last_rfwe", orfwe32, 1);

    // Reset in the third BUSY cycle, then a fresh SB completes
    present(MEM_LOAD, LS_WORD, 1'b0, 16'h0004, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rb_req_before", req32, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    present(MEM_STORE, LS_BYTE, 1'b0, 16'h0001, 32'h000000AB);
    @(negedge clk);
    chk("rb_req", req32, 0);
    chk("rb_valid", ov32, 0);
    chk("rb_stall", stall32, 1);
    ack_now();
    chk("rb_be", be32, 4'b0010);
    chk("rb_wdata", wd32, 32'hABABABAB);
    finish_op();
    chk("rb_done_valid", ov32, 1);
    chk("rb_done_excp", oexcp32, 0);

    // 64-bit instance: LH signed from the top lanes
    rst = 1'b1;
    valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    present(MEM_LOAD, LS_HALF, 1'b1, 16'h000E, 32'h0);
    rdata64 = 64'h8001_0000_0000_0000;
    @(negedge clk);
    chk("w64_stall", stall64, 1);
    @(posedge clk); #1;
    ack64 = 1'b1;
    @(negedge clk);
    chk("w64_req", req64, 1);
    chk("w64_be", be64, 8'hC0);
    chk("w64_addr", addr64, 16'h0008);
    @(posedge clk); #1;
    ack64 = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    chk("w64_valid", ov64, 1);
    chk("w64_rdata", ordata64, 32'hFFFF8001);
    chk("w64_excp", oexcp64, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
